// File: rtl/uart_rx_shift.sv
// UART receive shifter: oversampled start detection, 5..8 data bits, optional parity, one stop bit.
// Reports the character with parity, framing and break flags on a one-cycle valid pulse.
module uart_rx_shift (
    input  logic       bclk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic       serial_in,
    input  logic       osm_sel_in,
    input  logic [1:0] wls_in,
    input  logic       pen_in,
    input  logic       eps_in,
    input  logic       sp_in,
    output logic [7:0] rbr_out,
    output logic       data_valid_out,
    output logic       pe_out,
    output logic       fe_out,
    output logic       bi_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StParity   = 3'd3,
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q;
    logic       line;

    logic       osm_q;
    logic [1:0] wls_q;
    logic       pen_q, eps_q, sp_q;

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] osr_last, half_last;
    logic [2:0] bit_cnt_q, last_bit;
    logic [7:0] shift_q, rbr_q;
    logic       zero_q, par_err_q;
    logic       dv_q, pe_q, fe_q, bi_q;

    logic       bit_tick, start_det, start_ok;
    logic       sample_data, sample_par, sample_stop;
    logic       par_exp, busy;

    assign line      = sync_q[1];
    assign osr_last  = osm_q ? 4'd12 : 4'd15;
    assign half_last = osm_q ? 4'd5  : 4'd7;
    assign last_bit  = {1'b0, wls_q} + 3'd4;
    assign bit_tick  = (cnt_q == osr_last);

    // Unused upper bits of shift_q stay 0, so a full reduction covers only the data bits.
    assign par_exp = sp_q ? ~eps_q : (eps_q ? ^shift_q : ~(^shift_q));

    always_ff @(posedge bclk_in) begin
        if (rst_in) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    // State register
    always_ff @(posedge bclk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable_in) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!line) state_d = StStart;
                end
                StStart: begin
                    if (cnt_q == half_last) state_d = line ? StIdle : StData;
                end
                StData: begin
                    if (bit_tick && (bit_cnt_q == last_bit)) state_d = pen_q ? StParity : StStop;
                end
                StParity: begin
                    if (bit_tick) state_d = StStop;
                end
                StStop: begin
                    if (bit_tick) state_d = line ? StIdle : StWaitHigh;
                end
                StWaitHigh: begin
                    if (line) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output and strobe decode
    always_comb begin
        busy        = (state_q != StIdle);
        start_det   = enable_in && (state_q == StIdle) && !line;
        start_ok    = enable_in && (state_q == StStart) && (cnt_q == half_last) && !line;
        sample_data = enable_in && (state_q == StData) && bit_tick;
        sample_par  = enable_in && (state_q == StParity) && bit_tick;
        sample_stop = enable_in && (state_q == StStop) && bit_tick;

        // Any state change restarts the bit timer.
        if ((state_d != state_q) || bit_tick || start_ok) begin
            cnt_d = 4'd0;
        end else if ((state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge bclk_in) begin
        if (rst_in) begin
            cnt_q     <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            zero_q    <= 1'b0;
            par_err_q <= 1'b0;
            osm_q     <= 1'b0;
            wls_q     <= 2'd0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            rbr_q     <= 8'd0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dv_q  <= 1'b0;
            if (start_det) begin
                osm_q     <= osm_sel_in;
                wls_q     <= wls_in;
                pen_q     <= pen_in;
                eps_q     <= eps_in;
                sp_q      <= sp_in;
                bit_cnt_q <= 3'd0;
                shift_q   <= 8'd0;
                zero_q    <= 1'b1;
                par_err_q <= 1'b0;
            end
            if (sample_data) begin
                shift_q[bit_cnt_q] <= line;
                bit_cnt_q          <= bit_cnt_q + 3'd1;
                zero_q             <= zero_q & ~line;
            end
            if (sample_par) begin
                par_err_q <= (line != par_exp);
                zero_q    <= zero_q & ~line;
            end
            if (sample_stop) begin
                rbr_q <= shift_q;
                pe_q  <= par_err_q;
                fe_q  <= ~line;
                bi_q  <= zero_q & ~line;
                dv_q  <= 1'b1;
            end
        end
    end

    assign rbr_out        = rbr_q;
    assign data_valid_out = dv_q;
    assign pe_out         = pe_q;
    assign fe_out         = fe_q;
    assign bi_out         = bi_q;
    assign busy_out       = busy;

endmodule

// File: tb/tb_uart_rx_shift.sv
// Self-checking bench for uart_rx_shift: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx_shift;

    logic       bclk_in = 1'b0;
    logic       rst_in;
    logic       enable_in;
    logic       serial_in;
    logic       osm_sel_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic [7:0] rbr_out;
    logic       data_valid_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;

    int         pulse_cnt   = 0;
    int         busy_cycles = 0;
    logic [7:0] cap_rbr     = 8'd0;
    logic       cap_pe      = 1'b0;
    logic       cap_fe      = 1'b0;
    logic       cap_bi      = 1'b0;

    always #5 bclk_in = ~bclk_in;

    uart_rx_shift dut (
        .bclk_in        (bclk_in),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .serial_in      (serial_in),
        .osm_sel_in     (osm_sel_in),
        .wls_in         (wls_in),
        .pen_in         (pen_in),
        .eps_in         (eps_in),
        .sp_in          (sp_in),
        .rbr_out        (rbr_out),
        .data_valid_out (data_valid_out),
        .pe_out         (pe_out),
        .fe_out         (fe_out),
        .bi_out         (bi_out),
        .busy_out       (busy_out)
    );

    // Sole writer of the monitor counters; tests work from before/after snapshots.
    always @(negedge bclk_in) begin
        if (data_valid_out) begin
            pulse_cnt = pulse_cnt + 1;
            cap_rbr   = rbr_out;
            cap_pe    = pe_out;
            cap_fe    = fe_out;
            cap_bi    = bi_out;
        end
        if (busy_out) busy_cycles = busy_cycles + 1;
    end

    // Reference model: what a received frame must report.
    function automatic void model(input logic [1:0] wls, input logic pen, input logic eps,
                                  input logic sp, input logic [7:0] data, input logic par_bit,
                                  input logic stop_bit, output logic [7:0] e_rbr,
                                  output logic e_pe, output logic e_fe, output logic e_bi);
        int   nb;
        int   ones;
        logic exp_par;
        nb    = 5 + int'(wls);
        e_rbr = data & 8'((1 << nb) - 1);
        ones  = $countones(e_rbr);
        if (sp) exp_par = !eps;
        else if (eps) exp_par = (ones % 2) == 1;
        else exp_par = (ones % 2) == 0;
        e_pe = pen && (par_bit != exp_par);
        e_fe = !stop_bit;
        e_bi = (e_rbr == 8'd0) && (!pen || !par_bit) && !stop_bit;
    endfunction

    function automatic logic correct_parity(input logic [1:0] wls, input logic eps, input logic sp,
                                            input logic [7:0] data);
        int ones;
        ones = $countones(data & 8'((1 << (5 + int'(wls))) - 1));
        if (sp) return !eps;
        return eps ? ((ones % 2) == 1) : ((ones % 2) == 0);
    endfunction

    task automatic hold(input logic v, input int n);
        serial_in = v;
        repeat (n) @(negedge bclk_in);
    endtask

    // Drives one frame; leaves the line at the stop value at the end of the stop bit.
    task automatic send_frame(input logic osm, input logic [1:0] wls, input logic pen,
                              input logic eps, input logic sp, input logic [7:0] data,
                              input logic par_bit, input logic stop_bit, input logic scramble);
        int osr;
        osr        = osm ? 13 : 16;
        osm_sel_in = osm;
        wls_in     = wls;
        pen_in     = pen;
        eps_in     = eps;
        sp_in      = sp;
        hold(1'b0, 4);
        if (scramble) begin
            osm_sel_in = 1'($urandom);
            wls_in     = 2'($urandom);
            pen_in     = 1'($urandom);
            eps_in     = 1'($urandom);
            sp_in      = 1'($urandom);
        end
        hold(1'b0, osr - 4);
        for (int i = 0; i < 5 + int'(wls); i++) hold(data[i], osr);
        if (pen) hold(par_bit, osr);
        hold(stop_bit, osr);
    endtask

    task automatic test_reset;
        rst_in    = 1'b1;
        enable_in = 1'b1;
        serial_in = 1'b1;
        osm_sel_in = 1'b0; wls_in = 2'd3; pen_in = 1'b0; eps_in = 1'b0; sp_in = 1'b0;
        repeat (3) @(negedge bclk_in);
        rst_in = 1'b0;
        @(negedge bclk_in);
        checks++; if (rbr_out !== 8'd0) begin errors++; $display("FAIL reset_rbr got %h want 00", rbr_out); end
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid_out); end
        checks++; if ({pe_out, fe_out, bi_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {pe_out, fe_out, bi_out}); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
    endtask

    task automatic test_basic;
        int p0;
        p0 = pulse_cnt;
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy_out); end
        hold(1'b1, 8);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", pulse_cnt - p0); end
        checks++; if (cap_rbr !== 8'hA5) begin errors++; $display("FAIL basic_rbr got %h want a5", cap_rbr); end
        checks++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {cap_pe, cap_fe, cap_bi}); end
        checks++; if (rbr_out !== 8'hA5) begin errors++; $display("FAIL basic_hold got %h want a5", rbr_out); end
    endtask

    task automatic test_false_start;
        int p0;
        int b0;
        p0 = pulse_cnt;
        b0 = busy_cycles;
        hold(1'b0, 4);
        hold(1'b1, 40);
        checks++; if (busy_cycles == b0) begin errors++; $display("FAIL false_start_entered got 0 busy cycles want >0"); end
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL false_start_pulses got %0d want 0", pulse_cnt - p0); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL false_start_idle got %b want 0", busy_out); end
    endtask

    task automatic test_parity_err;
        int p0;
        p0 = pulse_cnt;
        send_frame(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 8);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL par_pulses got %0d want 1", pulse_cnt - p0); end
        checks++; if (cap_rbr !== 8'h35) begin errors++; $display("FAIL par_rbr got %h want 35", cap_rbr); end
        checks++; if ({cap_pe, cap_fe} !== 2'b10) begin errors++; $display("FAIL par_flags got pe=%b fe=%b want pe=1 fe=0", cap_pe, cap_fe); end
    endtask

    task automatic test_break;
        int p0;
        p0 = pulse_cnt;
        osm_sel_in = 1'b0; wls_in = 2'd3; pen_in = 1'b0; eps_in = 1'b0; sp_in = 1'b0;
        hold(1'b0, 20 * 16);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL break_pulses got %0d want 1", pulse_cnt - p0); end
        checks++; if ({cap_rbr, cap_fe, cap_bi} !== {8'h00, 2'b11}) begin errors++; $display("FAIL break_result got rbr=%h fe=%b bi=%b want rbr=00 fe=1 bi=1", cap_rbr, cap_fe, cap_bi); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL break_wait_high got %b want 1", busy_out); end
        hold(1'b1, 6);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL break_release got %b want 0", busy_out); end
    endtask

    task automatic test_stick;
        int p0;
        p0 = pulse_cnt;
        send_frame(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 8);
        checks++; if ({cap_rbr, cap_pe} !== {8'h1F, 1'b0}) begin errors++; $display("FAIL stick_ok got rbr=%h pe=%b want rbr=1f pe=0", cap_rbr, cap_pe); end
        send_frame(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 8);
        checks++; if ({cap_rbr, cap_pe} !== {8'h1F, 1'b1}) begin errors++; $display("FAIL stick_bad got rbr=%h pe=%b want rbr=1f pe=1", cap_rbr, cap_pe); end
        checks++; if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL stick_pulses got %0d want 2", pulse_cnt - p0); end
    endtask

    task automatic test_abort;
        int p0;
        osm_sel_in = 1'b0; wls_in = 2'd3; pen_in = 1'b0;
        p0 = pulse_cnt;
        hold(1'b0, 16);
        hold(1'b0, 48);
        rst_in = 1'b1;
        hold(1'b1, 1);
        rst_in = 1'b0;
        hold(1'b1, 200);
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL abort_rst_pulses got %0d want 0", pulse_cnt - p0); end
        checks++; if ({rbr_out, pe_out, fe_out, bi_out, busy_out} !== 12'h000) begin errors++; $display("FAIL abort_rst_outputs got rbr=%h flags=%b busy=%b want zeros", rbr_out, {pe_out, fe_out, bi_out}, busy_out); end

        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 8);
        p0 = pulse_cnt;
        hold(1'b0, 16);
        hold(1'b0, 32);
        enable_in = 1'b0;
        hold(1'b0, 2);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_en_idle got %b want 0", busy_out); end
        hold(1'b0, 16 * 6);
        hold(1'b1, 20);
        enable_in = 1'b1;
        hold(1'b1, 4);
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL abort_en_pulses got %0d want 0", pulse_cnt - p0); end
        checks++; if ({rbr_out, pe_out, fe_out, bi_out} !== {8'h3C, 3'b000}) begin errors++; $display("FAIL abort_en_held got rbr=%h flags=%b want rbr=3c flags=000", rbr_out, {pe_out, fe_out, bi_out}); end
    endtask

    // Random frames, some back to back, with config inputs scrambled mid-frame.
    task automatic test_random;
        logic       osm, pen, eps, sp, par_bit, stop_bit, scr;
        logic [1:0] wls;
        logic [7:0] data, e_rbr;
        logic       e_pe, e_fe, e_bi;
        int         p0;
        stop_bit = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (!stop_bit || ($urandom_range(0, 2) != 0)) hold(1'b1, $urandom_range(3, 20));
            osm      = 1'($urandom);
            wls      = 2'($urandom);
            pen      = 1'($urandom);
            eps      = 1'($urandom);
            sp       = 1'($urandom_range(0, 3) == 0);
            data     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            par_bit  = correct_parity(wls, eps, sp, data) ^ ($urandom_range(0, 3) == 0);
            if (data == 8'h00 && $urandom_range(0, 1) == 1) par_bit = 1'b0;
            stop_bit = ($urandom_range(0, 5) != 0);
            scr      = 1'($urandom);
            model(wls, pen, eps, sp, data, par_bit, stop_bit, e_rbr, e_pe, e_fe, e_bi);
            p0 = pulse_cnt;
            send_frame(osm, wls, pen, eps, sp, data, par_bit, stop_bit, scr);
            checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL rand%0d_pulses got %0d want 1", n, pulse_cnt - p0); end
            checks++; if ({cap_rbr, cap_pe, cap_fe, cap_bi} !== {e_rbr, e_pe, e_fe, e_bi}) begin
                errors++;
                $display("FAIL rand%0d_frame got rbr=%h pe=%b fe=%b bi=%b want rbr=%h pe=%b fe=%b bi=%b",
                         n, cap_rbr, cap_pe, cap_fe, cap_bi, e_rbr, e_pe, e_fe, e_bi);
            end
            checks++; if (busy_out !== !stop_bit) begin errors++; $display("FAIL rand%0d_busy got %b want %b", n, busy_out, !stop_bit); end
        end
        hold(1'b1, 20);
    endtask

    initial begin
        @(negedge bclk_in);
        test_reset();
        test_basic();
        test_false_start();
        test_parity_err();
        test_break();
        test_stick();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
